mem_stream_out: RTL and testbench

- Reads a block of words from a synchronous-read block RAM (1-cycle read latency).
- Emits the words, in address order, on a valid/ready byte stream with a last marker.
- It is the reverse direction of the team's memory-to-memory transfer path: that path fills the destination RAM, and this block drains a RAM to a downstream consumer (UART/FIFO/checker).
- Fully handles downstream backpressure without losing or duplicating words.

---
 rtl/mem_xfer_pkg.sv | 17 +
 rtl/mem_stream_skid.sv | 78 +++++++
 rtl/mem_stream_skid_chk.sv | 12 +
 rtl/mem_stream_out.sv | 144 ++++++++++++++
 tb/tb_mem_stream_out.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_xfer_pkg.sv
// Shared definitions for the memory transfer / memory stream blocks:
// FSM state encoding, default widths and the data offset used by the transfer path.
package mem_xfer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;

  // The transfer path adds this to every word it writes.
  localparam int OFFSET = 42;

endpackage

// File: rtl/mem_stream_skid.sv
// Two-entry FIFO holding RAM read data until the downstream consumer accepts it.
module mem_stream_skid #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] entry_q [2];
  logic [DATA_W-1:0] entry_d [2];
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr_q, wr_ptr_d;
  logic [1:0]        count_q, count_d;
  logic              do_push_s, do_pop_s;

  assign empty = (count_q == 2'd0);
  assign full  = (count_q == 2'd2);
  assign count = count_q;
  assign dout  = entry_q[rd_ptr_q];

  assign do_pop_s  = pop && !empty;
  assign do_push_s = push && (!full || do_pop_s);

  // Pointer, storage and occupancy update.
  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      entry_d[wr_ptr_q] = din;
      wr_ptr_d          = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Buffer state registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      entry_q[0] <= {DATA_W{1'b0}};
      entry_q[1] <= {DATA_W{1'b0}};
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      entry_q    <= entry_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  mem_stream_skid_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .full  (full)
  );

endmodule

// File: rtl/mem_stream_skid_chk.sv
// Simulation checks for the two-entry stream buffer.
module mem_stream_skid_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);

  // The read-issue rule guarantees a slot for every word in flight.
  a_no_push_full: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

// File: rtl/mem_stream_out.sv
// Drains a block of a 1-cycle-latency RAM onto a valid/ready byte stream with a last marker.
// Define MEMSTREAM_UNDO_OFFSET_EN to subtract the transfer-path OFFSET from every emitted word.
module mem_stream_out
  import mem_xfer_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [ADDR_W:0]   len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_din,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W:0]   CNT_ZERO  = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0]   CNT_ONE   = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   issued_q, issued_d;
  logic [ADDR_W:0]   sent_q, sent_d;
  logic              inflight_q, inflight_d;

  logic [DATA_W-1:0] head_s;
  logic              empty_s, full_s;
  logic [1:0]        count_s;
  logic              fire_s, last_s, mem_re_s;
  logic [2:0]        occ_after_s;

  mem_stream_skid #(.DATA_W(DATA_W)) u_skid (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_q),
    .din   (mem_din),
    .pop   (fire_s),
    .dout  (head_s),
    .empty (empty_s),
    .full  (full_s),
    .count (count_s)
  );

  assign fire_s = !empty_s && out_ready;
  assign last_s = (sent_q == (len_q - CNT_ONE));

  // Occupancy after this cycle's pop plus the word still coming back from the RAM;
  // crediting the pop lets a steady stream run at one beat per cycle.
  assign occ_after_s = {1'b0, count_s} + {2'b00, inflight_q} - {2'b00, fire_s};
  assign mem_re_s    = (state_q == ST_RUN) && (issued_q < len_q) &&
                       (occ_after_s < 3'd2) && !full_s;

  assign mem_addr  = addr_q;
  assign mem_re    = mem_re_s;
  assign out_valid = !empty_s;
  assign out_last  = !empty_s && last_s;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_FIN);

`ifdef MEMSTREAM_UNDO_OFFSET_EN
  assign out_data = head_s - DATA_W'(OFFSET);
`else
  assign out_data = head_s;
`endif

  // Next-state, address and counter logic.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    len_d      = len_q;
    issued_d   = issued_q;
    sent_d     = sent_q;
    inflight_d = mem_re_s;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len != CNT_ZERO) begin
            state_d  = ST_RUN;
            addr_d   = start_addr;
            len_d    = len;
            issued_d = CNT_ZERO;
            sent_d   = CNT_ZERO;
          end else begin
            state_d  = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (mem_re_s) begin
          addr_d   = addr_q + ADDR_ONE;
          issued_d = issued_q + CNT_ONE;
        end else begin
          addr_d   = addr_q;
          issued_d = issued_q;
        end
        if (fire_s) begin
          sent_d  = sent_q + CNT_ONE;
          state_d = last_s ? ST_FIN : ST_RUN;
        end else begin
          sent_d  = sent_q;
          state_d = ST_RUN;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control registers; reset abandons any block in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      len_q      <= CNT_ZERO;
      issued_q   <= CNT_ZERO;
      sent_q     <= CNT_ZERO;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      issued_q   <= issued_d;
      sent_q     <= sent_d;
      inflight_q <= inflight_d;
    end
  end

endmodule

// File: tb/tb_mem_stream_out.sv
// Table-driven bench for mem_stream_out with a 1-cycle-latency RAM model.
module tb_mem_stream_out;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1024;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [AW-1:0] start_addr;
  logic [AW:0]   len;
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic [DW-1:0] mem_din = 8'h00;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic          done;

  mem_stream_out dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr), .len(len),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_din(mem_din),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [DEPTH];

  always @(posedge clk) begin
    if (mem_re) mem_din <= ram[mem_addr];
  end

  typedef struct {
    logic [9:0]  sa;
    logic [10:0] len;
    logic [31:0] pat;
    int          hold_from;
    int          hold_len;
    int          restart;
    logic [7:0]  exp_first;
    logic [7:0]  exp_last;
    bit          full_rate;
  } vec_t;

  vec_t vecs[7];

  int checks = 0;
  int failures = 0;

  int k_cyc, issued_n, fired_n, viol, stab_err, done_cnt, done_cyc;
  int first_valid_cyc, first_fire_cyc, last_fire_cyc;
  bit busy_seen, valid_seen, prev_hold, prev_last;
  logic [7:0] prev_data;
  logic [7:0] bd[$];
  bit         bl[$];
  logic [9:0] ad[$];

  function automatic logic [7:0] adj(input logic [7:0] v);
`ifdef MEMSTREAM_UNDO_OFFSET_EN
    return v - 8'd42;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic clear_mon();
    k_cyc = 0; issued_n = 0; fired_n = 0; viol = 0; stab_err = 0;
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; first_fire_cyc = -1; last_fire_cyc = -1;
    busy_seen = 1'b0; valid_seen = 1'b0; prev_hold = 1'b0; prev_last = 1'b0; prev_data = 8'h00;
    bd.delete(); bl.delete(); ad.delete();
  endtask

  // One clock: drive at the falling edge, sample just after it.
  task automatic cycle(input bit st, input bit rdy);
    bit fire;
    @(negedge clk);
    start = st;
    out_ready = rdy;
    #1;
    fire = out_valid && out_ready;
    if (prev_hold && (!out_valid || out_data !== prev_data || out_last !== prev_last)) stab_err++;
    if (mem_re) begin
      if ((issued_n - fired_n - int'(fire)) >= 2) viol++;
      ad.push_back(mem_addr);
      issued_n++;
    end
    if (out_valid && first_valid_cyc < 0) first_valid_cyc = k_cyc;
    if (fire) begin
      bd.push_back(out_data);
      bl.push_back(out_last);
      if (first_fire_cyc < 0) first_fire_cyc = k_cyc;
      last_fire_cyc = k_cyc;
      fired_n++;
    end
    if (done) begin
      done_cnt++;
      if (done_cyc < 0) done_cyc = k_cyc;
    end
    busy_seen  = busy_seen | busy;
    valid_seen = valid_seen | out_valid;
    prev_hold  = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    k_cyc++;
  endtask

  task automatic run_block(input vec_t v, output bit timed_out);
    bit rdy;
    clear_mon();
    start_addr = v.sa;
    len = v.len;
    timed_out = 1'b1;
    for (int k = 0; k < int'(v.len) * 4 + 60; k++) begin
      rdy = v.pat[k % 32];
      if (k >= v.hold_from && k < v.hold_from + v.hold_len) rdy = 1'b0;
      cycle((k == 0) || (k == v.restart), rdy);
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
    for (int k = 0; k < 8; k++) cycle(1'b0, 1'b1);
  endtask

  task automatic check_block(input vec_t v, input int idx, input bit timed_out);
    int n, dm, am, lc, lpos;
    n = int'(v.len);
    chk($sformatf("v%0d_timeout", idx), int'(timed_out), 0);
    chk($sformatf("v%0d_beats", idx), bd.size(), n);
    chk($sformatf("v%0d_reads", idx), ad.size(), n);
    dm = 0; lc = 0; lpos = -1;
    foreach (bd[i]) begin
      if (bd[i] !== adj(ram[(int'(v.sa) + i) % DEPTH])) dm++;
      if (bl[i]) begin lc++; lpos = i; end
    end
    am = 0;
    foreach (ad[i]) if (int'(ad[i]) != (int'(v.sa) + i) % DEPTH) am++;
    chk($sformatf("v%0d_data_errs", idx), dm, 0);
    chk($sformatf("v%0d_addr_errs", idx), am, 0);
    chk($sformatf("v%0d_done_cnt", idx), done_cnt, 1);
    chk($sformatf("v%0d_stall_stable", idx), stab_err, 0);
    chk($sformatf("v%0d_issue_rule", idx), viol, 0);
    if (n > 0) begin
      chk($sformatf("v%0d_last_cnt", idx), lc, 1);
      chk($sformatf("v%0d_last_pos", idx), lpos, n - 1);
      chk($sformatf("v%0d_busy_seen", idx), int'(busy_seen), 1);
      if (bd.size() > 0) begin
        chk($sformatf("v%0d_first_data", idx), int'(bd[0]), int'(adj(v.exp_first)));
        chk($sformatf("v%0d_last_data", idx), int'(bd[bd.size()-1]), int'(adj(v.exp_last)));
      end
      if (v.full_rate) begin
        chk($sformatf("v%0d_first_lat", idx), first_valid_cyc, 3);
        chk($sformatf("v%0d_burst_span", idx), last_fire_cyc - first_fire_cyc, n - 1);
        chk($sformatf("v%0d_done_lat", idx), done_cyc - last_fire_cyc, 1);
      end
    end else begin
      chk($sformatf("v%0d_len0_done", idx), done_cyc, 1);
      chk($sformatf("v%0d_len0_valid", idx), int'(valid_seen), 0);
      chk($sformatf("v%0d_len0_busy", idx), int'(busy_seen), 0);
    end
  endtask

  function automatic int out_vec();
    return int'({mem_addr, mem_re, out_data, out_valid, out_last, busy, done});
  endfunction

  initial begin
    bit to;
    vec_t rv;
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; start_addr = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) ram[i] = 8'(i);
    ram[10'h200] = 8'h2A;
    ram[10'h201] = 8'h05;

    vecs[0] = '{sa:10'h000, len:11'd4,    pat:32'hFFFF_FFFF, hold_from:0, hold_len:0, restart:-1,
                exp_first:8'h00, exp_last:8'h03, full_rate:1'b1};
    vecs[1] = '{sa:10'h3FE, len:11'd4,    pat:32'hFFFF_FFFF, hold_from:0, hold_len:0, restart:-1,
                exp_first:8'hFE, exp_last:8'h01, full_rate:1'b1};
    vecs[2] = '{sa:10'h040, len:11'd8,    pat:32'h5A3C_96E1, hold_from:5, hold_len:5, restart:-1,
                exp_first:8'h40, exp_last:8'h47, full_rate:1'b0};
    vecs[3] = '{sa:10'h100, len:11'd0,    pat:32'hFFFF_FFFF, hold_from:0, hold_len:0, restart:-1,
                exp_first:8'h00, exp_last:8'h00, full_rate:1'b1};
    vecs[4] = '{sa:10'h200, len:11'd2,    pat:32'hFFFF_FFFF, hold_from:0, hold_len:0, restart:1,
                exp_first:8'h2A, exp_last:8'h05, full_rate:1'b1};
    vecs[5] = '{sa:10'h300, len:11'd2,    pat:32'hFFFF_FFFF, hold_from:0, hold_len:0, restart:5,
                exp_first:8'h00, exp_last:8'h01, full_rate:1'b1};
    vecs[6] = '{sa:10'h123, len:11'd1024, pat:32'hFFFF_FFFF, hold_from:0, hold_len:0, restart:-1,
                exp_first:8'h23, exp_last:8'h22, full_rate:1'b1};

    #12;
    chk("reset_outputs", out_vec(), 0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      run_block(vecs[i], to);
      check_block(vecs[i], i, to);
    end

    // Reset while the second beat of a 6-word block is on the bus.
    clear_mon();
    start_addr = 10'h000;
    len = 11'd6;
    cycle(1'b1, 1'b1);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1);
    @(negedge clk);
    #1;
    chk("rst_pre_valid", int'(out_valid), 1);
    chk("rst_pre_data", int'(out_data), int'(adj(8'h01)));
    #1;
    reset = 1'b1;
    #1;
    chk("rst_async_outputs", out_vec(), 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    for (int k = 0; k < 6; k++) cycle(1'b0, 1'b1);
    chk("rst_no_done", done_cnt, 0);
    chk("rst_no_beats", bd.size(), 0);
    chk("rst_no_reads", ad.size(), 0);

    rv = '{sa:10'h010, len:11'd2, pat:32'hFFFF_FFFF, hold_from:0, hold_len:0, restart:-1,
           exp_first:8'h10, exp_last:8'h11, full_rate:1'b1};
    run_block(rv, to);
    check_block(rv, 7, to);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
